// File: rtl/sprite_layer_renderer.sv
// Composites NUM_SPRITES positioned, integer-scaled, animated sprites over a background
// colour with a fixed 2-cycle pipeline. Optional macro SPRITE_FLIP_EN adds per-slot mirroring.
module sprite_layer_renderer #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int SCALE_LOG2  = 1,
    parameter int NUM_FRAMES  = 2,
    parameter int FRAME_DIV   = 8,
    parameter int IDX_W       = 4,
    parameter int TRANSP_IDX  = 0,
    localparam int ROM_AW     = $clog2(SPRITE_W * SPRITE_H * NUM_FRAMES),
    localparam int AF_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic                          blank,
    input  logic                          frame_start,
    input  logic [10*NUM_SPRITES-1:0]     sprite_x,
    input  logic [10*NUM_SPRITES-1:0]     sprite_y,
    input  logic [NUM_SPRITES-1:0]        sprite_en,
`ifdef SPRITE_FLIP_EN
    input  logic [NUM_SPRITES-1:0]        sprite_flip,
`endif
    input  logic [3:0]                    bg_red,
    input  logic [3:0]                    bg_green,
    input  logic [3:0]                    bg_blue,
    output logic [ROM_AW*NUM_SPRITES-1:0] rom_addr,
    input  logic [IDX_W*NUM_SPRITES-1:0]  rom_q,
    output logic [IDX_W-1:0]              pal_index,
    input  logic [3:0]                    pal_red,
    input  logic [3:0]                    pal_green,
    input  logic [3:0]                    pal_blue,
    output logic [3:0]                    red,
    output logic [3:0]                    green,
    output logic [3:0]                    blue,
    output logic [AF_W-1:0]               anim_frame
);

    localparam int FD_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [10:0]      SCR_W    = 11'(SPRITE_W << SCALE_LOG2);
    localparam logic [10:0]      SCR_H    = 11'(SPRITE_H << SCALE_LOG2);
    localparam logic [10:0]      TX_LAST  = 11'(SPRITE_W - 1);
    localparam logic [FD_W-1:0]  DIV_LAST = FD_W'(FRAME_DIV - 1);
    localparam logic [AF_W-1:0]  FRM_LAST = AF_W'(NUM_FRAMES - 1);
    localparam logic [IDX_W-1:0] TRANSP   = IDX_W'(TRANSP_IDX);

    logic [10*NUM_SPRITES-1:0] x_q, y_q;
    logic [NUM_SPRITES-1:0]    en_q, flip_s;
    logic [FD_W-1:0]           div_q, div_d;
    logic [AF_W-1:0]           anim_q, anim_d;
    logic [NUM_SPRITES-1:0]    hit_s, hit_q;
    logic                      blank_q;
    logic [10:0]               dx_s, dy_s, tx_s, ty_s;
    logic [31:0]               addr_s;
    logic                      win_s;
    logic [IDX_W-1:0]          pal_idx_s;
    logic [11:0]               rgb_d, rgb_q;

    // Slot placement is only sampled at vblank so a frame never tears.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            x_q  <= '0;
            y_q  <= '0;
            en_q <= '0;
        end else if (frame_start) begin
            x_q  <= sprite_x;
            y_q  <= sprite_y;
            en_q <= sprite_en;
        end
    end

`ifdef SPRITE_FLIP_EN
    logic [NUM_SPRITES-1:0] flip_q;
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            flip_q <= '0;
        end else if (frame_start) begin
            flip_q <= sprite_flip;
        end
    end
    assign flip_s = flip_q;
`else
    assign flip_s = '0;
`endif

    always_comb begin
        div_d  = div_q;
        anim_d = anim_q;
        if (frame_start) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (NUM_FRAMES <= 1) begin
                    anim_d = '0;
                end else if (anim_q == FRM_LAST) begin
                    anim_d = '0;
                end else begin
                    anim_d = anim_q + 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end else begin
            div_d  = div_q;
            anim_d = anim_q;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            anim_q <= '0;
        end else begin
            div_q  <= div_d;
            anim_q <= anim_d;
        end
    end

    // Differences are 11 bits wide so a pixel left of/above the sprite sets bit 10.
    always_comb begin
        hit_s    = '0;
        rom_addr = '0;
        dx_s     = '0;
        dy_s     = '0;
        tx_s     = '0;
        ty_s     = '0;
        addr_s   = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            dx_s   = {1'b0, DrawX} - {1'b0, x_q[10*i +: 10]};
            dy_s   = {1'b0, DrawY} - {1'b0, y_q[10*i +: 10]};
            tx_s   = flip_s[i] ? (TX_LAST - (dx_s >> SCALE_LOG2)) : (dx_s >> SCALE_LOG2);
            ty_s   = dy_s >> SCALE_LOG2;
            addr_s = 32'(anim_q) * 32'(SPRITE_W * SPRITE_H) + 32'(ty_s) * 32'(SPRITE_W) + 32'(tx_s);
            if (en_q[i] && !dx_s[10] && (dx_s < SCR_W) && !dy_s[10] && (dy_s < SCR_H)) begin
                hit_s[i]                      = 1'b1;
                rom_addr[ROM_AW*i +: ROM_AW]  = ROM_AW'(addr_s);
            end else begin
                hit_s[i]                      = 1'b0;
                rom_addr[ROM_AW*i +: ROM_AW]  = '0;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hit_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            hit_q   <= hit_s;
            blank_q <= blank;
        end
    end

    // Scanning from the highest slot down lets the lowest opaque slot overwrite.
    always_comb begin
        win_s     = 1'b0;
        pal_idx_s = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_q[i] && (rom_q[IDX_W*i +: IDX_W] != TRANSP)) begin
                win_s     = 1'b1;
                pal_idx_s = rom_q[IDX_W*i +: IDX_W];
            end else begin
                win_s     = win_s;
                pal_idx_s = pal_idx_s;
            end
        end
    end

    assign pal_index = pal_idx_s;

    always_comb begin
        rgb_d = 12'h000;
        if (!blank_q) begin
            rgb_d = 12'h000;
        end else if (win_s) begin
            rgb_d = {pal_red, pal_green, pal_blue};
        end else begin
            rgb_d = {bg_red, bg_green, bg_blue};
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign anim_frame = anim_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Directed self-checking bench for sprite_layer_renderer with a synchronous ROM model
// per slot and a small combinational palette.
module tb_sprite_layer_renderer;

    localparam int NS = 4;
    localparam int AW = 9;
    localparam int IW = 4;

    logic          vga_clk = 1'b0;
    logic          reset;
    logic [9:0]    DrawX, DrawY;
    logic          blank, frame_start;
    logic [10*NS-1:0] sprite_x, sprite_y;
    logic [NS-1:0] sprite_en;
`ifdef SPRITE_FLIP_EN
    logic [NS-1:0] sprite_flip;
`endif
    logic [3:0]    bg_red, bg_green, bg_blue;
    logic [AW*NS-1:0] rom_addr;
    logic [IW*NS-1:0] rom_q;
    logic [IW-1:0] pal_index;
    logic [3:0]    pal_red, pal_green, pal_blue;
    logic [3:0]    red, green, blue;
    logic [0:0]    anim_frame;

    logic [3:0]    rom_mem [NS][512];

    int total    = 0;
    int passed   = 0;
    int fails    = 0;
    int fs_count = 0;
    int exp_anim;

    always #5 vga_clk = ~vga_clk;

    sprite_layer_renderer dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .frame_start (frame_start),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .sprite_en   (sprite_en),
`ifdef SPRITE_FLIP_EN
        .sprite_flip (sprite_flip),
`endif
        .bg_red      (bg_red),
        .bg_green    (bg_green),
        .bg_blue     (bg_blue),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .pal_index   (pal_index),
        .pal_red     (pal_red),
        .pal_green   (pal_green),
        .pal_blue    (pal_blue),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .anim_frame  (anim_frame)
    );

    always @(posedge vga_clk) begin
        for (int i = 0; i < NS; i++) begin
            rom_q[IW*i +: IW] <= rom_mem[i][rom_addr[AW*i +: AW]];
        end
    end

    always_comb begin
        case (pal_index)
            4'd3:    {pal_red, pal_green, pal_blue} = 12'hF00;
            4'd5:    {pal_red, pal_green, pal_blue} = 12'h0F0;
            4'd7:    {pal_red, pal_green, pal_blue} = 12'h00F;
            default: {pal_red, pal_green, pal_blue} = 12'h111;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        fs_count++;
    endtask

    task automatic pix(input int x, input int y, input logic b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        step(2);
    endtask

    initial begin
        reset       = 1'b1;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        blank       = 1'b0;
        frame_start = 1'b0;
        sprite_x    = '0;
        sprite_y    = '0;
        sprite_en   = '0;
`ifdef SPRITE_FLIP_EN
        sprite_flip = '0;
`endif
        bg_red      = 4'h2;
        bg_green    = 4'h3;
        bg_blue     = 4'h4;
        for (int i = 0; i < NS; i++) begin
            for (int a = 0; a < 512; a++) begin
                rom_mem[i][a] = (i == 0) ? 4'd3 : 4'd0;
            end
        end

        step(2);
        chk("rst_rgb", 32'({red, green, blue}), 32'h000);
        chk("rst_pal", 32'(pal_index), 32'd0);
        chk("rst_anim", 32'(anim_frame), 32'd0);
        reset = 1'b0;

        // Single sprite at (100,50), scaled 2x -> 32x32 on screen
        sprite_x[9:0] = 10'd100;
        sprite_y[9:0] = 10'd50;
        sprite_en     = 4'b0001;
        fs_pulse();
        pix(99, 50, 1'b1);
        chk("bg_left", 32'({red, green, blue}), 32'h234);
        DrawX = 10'd100;
        step(1);
        chk("lat1_rgb", 32'({red, green, blue}), 32'h234);
        chk("lat1_pal", 32'(pal_index), 32'd3);
        step(1);
        chk("lat2_rgb", 32'({red, green, blue}), 32'hF00);
        pix(132, 50, 1'b1);
        chk("clip_right", 32'({red, green, blue}), 32'h234);
        pix(131, 50, 1'b1);
        chk("edge_in_x", 32'({red, green, blue}), 32'hF00);
        pix(100, 81, 1'b1);
        chk("edge_in_y", 32'({red, green, blue}), 32'hF00);
        pix(100, 82, 1'b1);
        chk("clip_bottom", 32'({red, green, blue}), 32'h234);
        pix(100, 50, 1'b0);
        chk("blanked", 32'({red, green, blue}), 32'h000);

        // Overlap of slots 0 and 1
        sprite_x[19:10] = 10'd100;
        sprite_y[19:10] = 10'd50;
        sprite_en       = 4'b0011;
        for (int a = 0; a < 512; a++) rom_mem[1][a] = 4'd5;
        rom_mem[0][0]   = 4'd0;
        rom_mem[0][256] = 4'd0;
        fs_pulse();
        DrawX = 10'd100;
        DrawY = 10'd50;
        blank = 1'b1;
        step(1);
        chk("ovl_transp_pal", 32'(pal_index), 32'd5);
        step(1);
        chk("ovl_transp_rgb", 32'({red, green, blue}), 32'h0F0);
        pix(102, 50, 1'b1);
        chk("ovl_opaque0", 32'({red, green, blue}), 32'hF00);
        rom_mem[1][0]   = 4'd0;
        rom_mem[1][256] = 4'd0;
        pix(100, 50, 1'b1);
        chk("all_transp_rgb", 32'({red, green, blue}), 32'h234);
        chk("all_transp_pal", 32'(pal_index), 32'd0);
        rom_mem[0][0]   = 4'd7;
        rom_mem[0][256] = 4'd7;
        pix(100, 50, 1'b1);
        chk("slot0_wins", 32'({red, green, blue}), 32'h00F);

        // Mid-frame position change must wait for frame_start
        sprite_x[9:0] = 10'd300;
        pix(302, 50, 1'b1);
        chk("no_tear_new", 32'({red, green, blue}), 32'h234);
        pix(102, 50, 1'b1);
        chk("no_tear_old", 32'({red, green, blue}), 32'hF00);
        fs_pulse();
        pix(302, 50, 1'b1);
        chk("moved_new", 32'({red, green, blue}), 32'hF00);
        pix(102, 50, 1'b1);
        chk("moved_old", 32'({red, green, blue}), 32'h0F0);

        // Animation: texel (3,2) of slot 0, frame offset 256
        DrawX = 10'd306;
        DrawY = 10'd54;
        #1;
        chk("rom_addr_unhit", 32'(rom_addr[AW*2 +: AW]), 32'd0);
        for (int k = 0; k < 16; k++) begin
            fs_pulse();
            exp_anim = (fs_count / 8) % 2;
            chk("anim_frame", 32'(anim_frame), 32'(exp_anim));
            chk("anim_addr", 32'(rom_addr[AW-1:0]), 32'(exp_anim * 256 + 35));
        end
        for (int k = 0; k < 5; k++) fs_pulse();
        chk("pre_rst_anim", 32'(anim_frame), 32'd1);

        // Asynchronous reset mid-cycle
        pix(302, 50, 1'b1);
        chk("pre_rst_rgb", 32'({red, green, blue}), 32'hF00);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_rgb", 32'({red, green, blue}), 32'h000);
        chk("async_rst_anim", 32'(anim_frame), 32'd0);
        chk("async_rst_pal", 32'(pal_index), 32'd0);
        step(1);
        chk("rst_edge_rgb", 32'({red, green, blue}), 32'h000);
        reset    = 1'b0;
        fs_count = 0;
        pix(302, 50, 1'b1);
        chk("no_draw_after_rst", 32'({red, green, blue}), 32'h234);
        fs_pulse();
        pix(302, 50, 1'b1);
        chk("redraw", 32'({red, green, blue}), 32'hF00);

        // Horizontal mirroring of slot 0 at the origin
`ifdef SPRITE_FLIP_EN
        sprite_flip = 4'b0001;
`endif
        sprite_x[9:0] = 10'd0;
        sprite_y[9:0] = 10'd0;
        fs_pulse();
        DrawX = 10'd0;
        DrawY = 10'd0;
        #1;
`ifdef SPRITE_FLIP_EN
        chk("flip_addr0", 32'(rom_addr[AW-1:0]), 32'd15);
`else
        chk("noflip_addr0", 32'(rom_addr[AW-1:0]), 32'd0);
`endif
        DrawX = 10'd2;
        #1;
`ifdef SPRITE_FLIP_EN
        chk("flip_addr2", 32'(rom_addr[AW-1:0]), 32'd14);
`else
        chk("noflip_addr2", 32'(rom_addr[AW-1:0]), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sprite_layer_renderer.md
Name: sprite_layer_renderer

Overview:
- Parametrised successor to the single full-screen sprite display: composites up to NUM_SPRITES positioned, integer-scaled, animated sprites over a background colour.
- Sits between the VGA timing generator (DrawX/DrawY/blank) and the VGA DAC outputs.
- Each sprite slot drives an external synchronous sprite ROM (1-cycle read latency). All slots share one external combinational palette.
- Pipelined, with fixed 2-cycle latency from pixel coordinate to registered RGB output.

Parameters:
- NUM_SPRITES, 4, number of sprite slots; slot 0 has highest draw priority.
- SPRITE_W, 16, sprite width in source texels.
- SPRITE_H, 16, sprite height in source texels.
- SCALE_LOG2, 1, on-screen scale factor is 2^SCALE_LOG2 in both axes.
- NUM_FRAMES, 2, animation frames stored consecutively in each ROM.
- FRAME_DIV, 8, number of video frames per animation step; minimum 1.
- IDX_W, 4, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent.
- ROM_AW, clog2(SPRITE_W*SPRITE_H*NUM_FRAMES), ROM address width; derived, not overridable.

Ports:
- vga_clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- frame_start  in  1  one-cycle pulse at the start of vertical blanking.
- sprite_x  in  10*NUM_SPRITES  top-left column per slot, packed with slot i at bits [10i+9:10i].
- sprite_y  in  10*NUM_SPRITES  top-left row per slot, packed the same way.
- sprite_en  in  NUM_SPRITES  per-slot enable.
- bg_red, bg_green, bg_blue  in  4 each  background colour.
- rom_addr  out  ROM_AW*NUM_SPRITES  per-slot ROM address; combinational from DrawX/DrawY and the shadow registers.
- rom_q  in  IDX_W*NUM_SPRITES  per-slot ROM data, valid one cycle after rom_addr.
- pal_index  out  IDX_W  palette index of the winning slot.
- pal_red, pal_green, pal_blue  in  4 each  combinational palette result for pal_index.
- red, green, blue  out  4 each  registered pixel colour.
- anim_frame  out  clog2(NUM_FRAMES) (min 1)  current animation frame.

Behaviour:
- Shadow registers:
  - sprite_x, sprite_y and sprite_en are latched into shadow registers only on a frame_start pulse. Mid-frame changes to these inputs never tear the image.
  - Reset clears the shadow registers: all positions 0, all enables 0.
- Stage 0 (combinational, per slot i):
  - dx = DrawX - x_i, dy = DrawY - y_i, computed 11 bits wide.
  - hit_i = en_i AND dx in [0, SPRITE_W<<SCALE_LOG2) AND dy in [0, SPRITE_H<<SCALE_LOG2). A negative difference is never a hit.
  - tx = dx>>SCALE_LOG2, ty = dy>>SCALE_LOG2.
  - rom_addr_i = anim_frame*SPRITE_W*SPRITE_H + ty*SPRITE_W + tx. When hit_i = 0, rom_addr_i = 0.
- Stage 1 (registered at the end of cycle 0):
  - hit_i and blank are registered and aligned with rom_q.
  - Winner = lowest i with hit_i = 1 and rom_q_i != TRANSP_IDX.
  - pal_index = rom_q of the winner; 0 if there is no winner.
- Stage 2 (registered at the end of cycle 1):
  - If delayed blank = 0: RGB = 0.
  - Else if a winner exists: RGB = pal_red/pal_green/pal_blue.
  - Else: RGB = bg_red/bg_green/bg_blue.
- Latency: exactly 2 vga_clk cycles from DrawX/DrawY/blank to red/green/blue.
- Animation counter:
  - frame_div_cnt increments on each frame_start.
  - On reaching FRAME_DIV-1 it wraps to 0 and anim_frame advances.
  - anim_frame wraps from NUM_FRAMES-1 to 0.
  - NUM_FRAMES = 1: anim_frame is held at 0.
- Boundaries:
  - Sprites partially off-screen (right or bottom) are clipped naturally.
  - A sprite at x=630 with 32-pixel scaled width draws only columns 630-639.
  - Overlapping opaque slots: the lower index wins.
  - All overlapping slots transparent at a pixel: background shows.
- Reset (asynchronous, any time, including mid-line): the pipeline is flushed. red/green/blue = 0, pal_index = 0, anim_frame = 0, frame_div_cnt = 0, all delayed hit/blank flags = 0.

Optional Feature:
- SPRITE_FLIP_EN.
- Defined:
  - Adds input port sprite_flip, NUM_SPRITES bits wide, shadowed on frame_start like the other slot inputs.
  - When a slot's flip bit = 1, tx = SPRITE_W-1-(dx>>SCALE_LOG2), which mirrors that slot horizontally.
- Undefined: the port is absent and tx is never mirrored.

Test Plan:
- Reset mid-frame with blank=1 → RGB = 0 on the next edge, anim_frame = 0, no sprite drawn until after the next frame_start.
- Slot 0 enabled at (100,50), SCALE_LOG2=1, ROM holds index 3 everywhere, palette 3 = F/0/0 → pixel (100,50) is red exactly 2 cycles later; pixels (99,50) and (132,50) show the background.
- Slots 0 and 1 overlap; slot 0 texel = TRANSP_IDX, slot 1 texel = 5 → pal_index = 5. Make slot 0's texel opaque → slot 0's colour wins.
- Change sprite_x mid-frame without a frame_start → output unchanged until a frame_start pulse, then the new position applies on the next frame.
- FRAME_DIV=8, NUM_FRAMES=2, apply 16 frame_start pulses → anim_frame toggles after pulses 8 and 16. rom_addr offset = 256 while anim_frame = 1.
- SPRITE_FLIP_EN defined, flip=1, sprite at x=0, DrawX=0 → rom_addr tx = 15.
